opr_sequencer: RTL



---
 rtl/opr_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/opr_sequencer.sv
// PDP-8 operate-instruction sequencer: applies group 1 / group 2 micro-ops to a
// captured AC/L one architectural event per clock, with a START/DONE handshake.
module opr_sequencer #(
  parameter int WORD_W     = 12,
  parameter bit ENABLE_BSW = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [11:0]       IR,
  input  logic [WORD_W-1:0] AC_IN,
  input  logic              L_IN,
  input  logic [WORD_W-1:0] SR,
  output logic              BUSY,
  output logic              DONE,
  output logic [WORD_W-1:0] AC_OUT,
  output logic              L_OUT,
  output logic              SKIP,
  output logic              HALT,
  output logic              ILLEGAL
);

  localparam int HALF = WORD_W / 2;

  typedef enum logic [2:0] {IDLE, EV1, EV2, EV3, EV4, EV4B, FIN} state_t;

  state_t            state_q, state_d;
  logic [8:0]        ir_q, ir_d;
  logic [WORD_W-1:0] ac_q, ac_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              l_q, l_d;
  logic              skip_q, skip_d;
  logic              halt_q, halt_d;
  logic              illegal_q, illegal_d;

  logic [WORD_W:0]   inc_sum;
  logic [WORD_W-1:0] rot_ac;
  logic              rot_l;
  logic              skip_hit;
  logic              one_rotate;
  logic              unused_ir;

  // Opcode bits are decoded upstream; only the microinstruction field matters here.
  assign unused_ir = ^IR[11:9];

  always_comb begin
    inc_sum    = {l_q, ac_q} + {{WORD_W{1'b0}}, 1'b1};
    one_rotate = ir_q[3] ^ ir_q[2];
    rot_ac     = ac_q;
    rot_l      = l_q;
    if (ir_q[3] && !ir_q[2]) begin
      rot_ac = {l_q, ac_q[WORD_W-1:1]};
      rot_l  = ac_q[0];
    end else if (ir_q[2] && !ir_q[3]) begin
      rot_ac = {ac_q[WORD_W-2:0], l_q};
      rot_l  = ac_q[WORD_W-1];
    end
    skip_hit = (ir_q[6] & ac_q[WORD_W-1]) | (ir_q[5] & (ac_q == '0)) | (ir_q[4] & l_q);
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ac_d      = ac_q;
    sr_d      = sr_q;
    l_d       = l_q;
    skip_d    = skip_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          ir_d      = IR[8:0];
          ac_d      = AC_IN;
          l_d       = L_IN;
          sr_d      = SR;
          skip_d    = 1'b0;
          halt_d    = 1'b0;
          illegal_d = IR[8] & IR[0];
          state_d   = (IR[8] & IR[0]) ? FIN : EV1;
        end
      end
      EV1: begin
        if (!ir_q[8]) begin
          if (ir_q[7]) ac_d = '0;
          if (ir_q[6]) l_d = 1'b0;
        end else begin
          // Skip is evaluated on the pre-CLA accumulator; IR[3] inverts the sense.
          skip_d = skip_hit ^ ir_q[3];
          if (ir_q[7]) ac_d = '0;
        end
        state_d = EV2;
      end
      EV2: begin
        if (!ir_q[8]) begin
          if (ir_q[5]) ac_d = ~ac_q;
          if (ir_q[4]) l_d = ~l_q;
        end else if (ir_q[2]) begin
          ac_d = ac_q | sr_q;
        end
        state_d = EV3;
      end
      EV3: begin
        if (!ir_q[8]) begin
          if (ir_q[0]) {l_d, ac_d} = inc_sum;
          state_d = EV4;
        end else begin
          if (ir_q[1]) halt_d = 1'b1;
          state_d = FIN;
        end
      end
      EV4: begin
        if (one_rotate) begin
          ac_d = rot_ac;
          l_d  = rot_l;
        end else if (ENABLE_BSW && ir_q[1] && !ir_q[3] && !ir_q[2]) begin
          ac_d = {ac_q[HALF-1:0], ac_q[WORD_W-1:HALF]};
        end
        state_d = (one_rotate && ir_q[1]) ? EV4B : FIN;
      end
      EV4B: begin
        ac_d    = rot_ac;
        l_d     = rot_l;
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      ac_q      <= '0;
      sr_q      <= '0;
      l_q       <= 1'b0;
      skip_q    <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ac_q      <= ac_d;
      sr_q      <= sr_d;
      l_q       <= l_d;
      skip_q    <= skip_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

  assign BUSY    = (state_q != IDLE);
  assign DONE    = (state_q == FIN);
  assign AC_OUT  = ac_q;
  assign L_OUT   = l_q;
  assign SKIP    = skip_q;
  assign HALT    = halt_q;
  assign ILLEGAL = illegal_q;

endmodule
